// File: rtl/vga_text_buffer.sv
// vga_text_buffer
//   Character-cell store sitting between a host/terminal writer and a VGA
//   text renderer. Each cell holds {ascii, fg, bg}. A small fill engine
//   implements clear-screen, clear-row and scroll-up; scrolling is done by
//   rotating a row-base offset and blanking one physical row, so no cell
//   data is moved. The buffer clears itself after reset.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   r_addr, c_addr                 renderer logical row / column
//   ascii, fg_color, bg_color      registered read data (1-cycle latency)
//   we, wr_addr, wc_addr,
//   w_ascii, w_fg_color, w_bg_color host cell write
//   cmd_valid, cmd_op, cmd_row     command request (00 clear all,
//                                  01 scroll up, 10 clear row, 11 no-op)
//   cmd_ready                      engine idle, command can be taken
//   cmd_done                       one-cycle completion pulse
//   busy                           engine active
module vga_text_buffer #(
  parameter int              ROWS   = 30,
  parameter int              COLS   = 70,
  parameter int              RBITS  = 5,
  parameter int              CBITS  = 7,
  parameter int              CW     = 3,
  parameter logic [CW-1:0]   DEF_FG = CW'(7),
  parameter logic [CW-1:0]   DEF_BG = CW'(0)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [RBITS-1:0] r_addr,
  input  logic [CBITS-1:0] c_addr,
  output logic [7:0]       ascii,
  output logic [CW-1:0]    fg_color,
  output logic [CW-1:0]    bg_color,
  input  logic             we,
  input  logic [RBITS-1:0] wr_addr,
  input  logic [CBITS-1:0] wc_addr,
  input  logic [7:0]       w_ascii,
  input  logic [CW-1:0]    w_fg_color,
  input  logic [CW-1:0]    w_bg_color,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_op,
  input  logic [RBITS-1:0] cmd_row,
  output logic             cmd_ready,
  output logic             cmd_done,
  output logic             busy
);

  localparam int CELLS = ROWS * COLS;
  localparam int IW    = $clog2(CELLS);
  localparam int WW    = 8 + 2 * CW;

  typedef logic [IW-1:0] idx_t;
  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

  localparam logic [WW-1:0]    BLANK     = {8'h20, DEF_FG, DEF_BG};
  localparam logic [RBITS:0]   ROWS_W    = (RBITS+1)'(ROWS);
  localparam logic [CBITS:0]   COLS_W    = (CBITS+1)'(COLS);
  localparam idx_t             LAST_CELL = idx_t'(CELLS - 1);
  localparam idx_t             ROW_SPAN  = idx_t'(COLS - 1);
  localparam logic [RBITS-1:0] LAST_ROW  = RBITS'(ROWS - 1);

  function automatic logic row_ok(input logic [RBITS-1:0] r);
    return {1'b0, r} < ROWS_W;
  endfunction

  function automatic logic col_ok(input logic [CBITS-1:0] c);
    return {1'b0, c} < COLS_W;
  endfunction

  // Logical-to-physical row: both operands are below ROWS, so a single
  // conditional subtract implements the modulo.
  function automatic logic [RBITS-1:0] phys_row(input logic [RBITS-1:0] lr,
                                                input logic [RBITS-1:0] b);
    logic [RBITS:0] s;
    s = {1'b0, lr} + {1'b0, b};
    if (s >= ROWS_W) s = s - ROWS_W;
    return s[RBITS-1:0];
  endfunction

  function automatic idx_t cell_idx(input logic [RBITS-1:0] pr,
                                    input logic [CBITS-1:0] c);
    return idx_t'(pr) * idx_t'(COLS) + idx_t'(c);
  endfunction

  logic [WW-1:0]    mem [CELLS];
  state_t           state, state_nx;
  logic [RBITS-1:0] base, base_nx;
  idx_t             fill_idx, fill_idx_nx;
  idx_t             fill_last, fill_last_nx;
  idx_t             row_start;
  logic             host_hit;
  idx_t             host_idx;
  logic             mem_we;
  idx_t             mem_waddr;
  logic [WW-1:0]    mem_wdata;
  logic             rd_ok;
  idx_t             rd_idx;
  logic [WW-1:0]    rd_q;

  assign host_hit = we && row_ok(wr_addr) && col_ok(wc_addr);
  assign host_idx = cell_idx(phys_row(wr_addr, base), wc_addr);
  assign rd_ok    = row_ok(r_addr) && col_ok(c_addr);
  assign rd_idx   = cell_idx(phys_row(r_addr, base), c_addr);

  assign cmd_ready = (state == S_IDLE);
  assign cmd_done  = (state == S_DONE);
  assign busy      = (state != S_IDLE);

  // Host writes win the single write port; the engine simply waits a cycle.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = host_idx;
    mem_wdata = {w_ascii, w_fg_color, w_bg_color};
    if (host_hit) begin
      mem_we = 1'b1;
    end else if (state == S_FILL) begin
      mem_we    = 1'b1;
      mem_waddr = fill_idx;
      mem_wdata = BLANK;
    end
  end

  // Storage is deliberately not reset; the fill engine blanks it.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Read port: separate process from the write, so a same-cell access in
  // one cycle returns the previous contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_q <= BLANK;
    else        rd_q <= rd_ok ? mem[rd_idx] : BLANK;
  end

  assign ascii    = rd_q[WW-1 -: 8];
  assign fg_color = rd_q[2*CW-1 -: CW];
  assign bg_color = rd_q[CW-1:0];

  // Reset lands directly in a full-screen fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_FILL;
      base      <= '0;
      fill_idx  <= '0;
      fill_last <= LAST_CELL;
    end else begin
      state     <= state_nx;
      base      <= base_nx;
      fill_idx  <= fill_idx_nx;
      fill_last <= fill_last_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    base_nx      = base;
    fill_idx_nx  = fill_idx;
    fill_last_nx = fill_last;
    row_start    = '0;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            2'b00: begin
              base_nx      = '0;
              fill_idx_nx  = '0;
              fill_last_nx = LAST_CELL;
              state_nx     = S_FILL;
            end
            2'b01: begin
              // The old top physical row becomes the new bottom logical row.
              base_nx      = (base == LAST_ROW) ? '0 : base + 1'b1;
              row_start    = cell_idx(base, '0);
              fill_idx_nx  = row_start;
              fill_last_nx = row_start + ROW_SPAN;
              state_nx     = S_FILL;
            end
            2'b10: begin
              if (row_ok(cmd_row)) begin
                row_start    = cell_idx(phys_row(cmd_row, base), '0);
                fill_idx_nx  = row_start;
                fill_last_nx = row_start + ROW_SPAN;
                state_nx     = S_FILL;
              end else begin
                state_nx = S_DONE;
              end
            end
            default: state_nx = S_DONE;
          endcase
        end
      end
      S_FILL: begin
        if (!host_hit) begin
          if (fill_idx == fill_last) state_nx = S_DONE;
          else                       fill_idx_nx = fill_idx + 1'b1;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_vga_text_buffer.sv
// tb_vga_text_buffer
//   Directed bench for vga_text_buffer. A logical-view screen model holds
//   the expected contents; scrolling shifts model rows. Read expectations
//   are queued when the address is driven and compared when data appears.
module tb_vga_text_buffer;

  localparam int ROWS = 30;
  localparam int COLS = 70;
  localparam logic [13:0] BLANK = {8'h20, 3'h7, 3'h0};

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [4:0] r_addr = '0;
  logic [6:0] c_addr = '0;
  logic [7:0] ascii;
  logic [2:0] fg_color, bg_color;
  logic       we = 1'b0;
  logic [4:0] wr_addr = '0;
  logic [6:0] wc_addr = '0;
  logic [7:0] w_ascii = '0;
  logic [2:0] w_fg_color = '0, w_bg_color = '0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = '0;
  logic [4:0] cmd_row = '0;
  logic       cmd_ready, cmd_done, busy;

  always #5 clk = ~clk;

  vga_text_buffer dut (
    .clk(clk), .rst_n(rst_n), .r_addr(r_addr), .c_addr(c_addr),
    .ascii(ascii), .fg_color(fg_color), .bg_color(bg_color),
    .we(we), .wr_addr(wr_addr), .wc_addr(wc_addr), .w_ascii(w_ascii),
    .w_fg_color(w_fg_color), .w_bg_color(w_bg_color),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_row(cmd_row),
    .cmd_ready(cmd_ready), .cmd_done(cmd_done), .busy(busy)
  );

  logic [13:0] model [ROWS][COLS];
  logic [13:0] exp_q [$];
  int vectors = 0;
  int miscompares = 0;

  function automatic logic [13:0] cur();
    return {ascii, fg_color, bg_color};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic m_clear_all();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) model[r][c] = BLANK;
  endtask

  task automatic m_scroll();
    for (int r = 0; r < ROWS - 1; r++)
      for (int c = 0; c < COLS; c++) model[r][c] = model[r+1][c];
    for (int c = 0; c < COLS; c++) model[ROWS-1][c] = BLANK;
  endtask

  task automatic host_write(input int r, input int c, input logic [13:0] v);
    @(negedge clk);
    we = 1'b1; wr_addr = 5'(r); wc_addr = 7'(c);
    {w_ascii, w_fg_color, w_bg_color} = v;
    @(negedge clk);
    we = 1'b0;
    if (r < ROWS && c < COLS) model[r][c] = v;
  endtask

  task automatic read_one(input int r, input int c, input string tag);
    @(negedge clk);
    r_addr = 5'(r); c_addr = 7'(c);
    exp_q.push_back((r < ROWS && c < COLS) ? model[r][c] : BLANK);
    @(negedge clk);
    check(tag, 32'(cur()), 32'(exp_q.pop_front()));
  endtask

  task automatic read_ascii(input int r, input int c, input logic [7:0] e, input string tag);
    @(negedge clk);
    r_addr = 5'(r); c_addr = 7'(c);
    @(negedge clk);
    check(tag, 32'(ascii), 32'(e));
  endtask

  task automatic scan_all(input string tag);
    bit pend = 1'b0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        @(negedge clk);
        if (pend) check(tag, 32'(cur()), 32'(exp_q.pop_front()));
        r_addr = 5'(r); c_addr = 7'(c);
        exp_q.push_back(model[r][c]);
        pend = 1'b1;
      end
    @(negedge clk);
    check(tag, 32'(cur()), 32'(exp_q.pop_front()));
  endtask

  task automatic issue(input logic [1:0] op, input int row);
    @(negedge clk);
    check("ready before cmd", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_row = 5'(row);
  endtask

  // Counts negedges until cmd_done. Optionally pulses a (to-be-ignored)
  // scroll command at pulse_at and host-writes cells on cycles wr_lo..wr_hi.
  task automatic wait_done(input string tag, input int expect_n, input int budget,
                           input int pulse_at, input int wr_lo, input int wr_hi);
    int n = 0;
    int drops = 0;
    bit seen = 1'b0;
    while (n < budget && !seen) begin
      @(negedge clk);
      n++;
      cmd_valid = 1'b0;
      we = 1'b0;
      if (cmd_done) seen = 1'b1;
      else begin
        if (!busy) drops++;
        if (n == pulse_at) begin cmd_valid = 1'b1; cmd_op = 2'b01; end
        if (n >= wr_lo && n <= wr_hi) begin
          we = 1'b1; wr_addr = 5'(10 + n - wr_lo); wc_addr = 7'(n);
          {w_ascii, w_fg_color, w_bg_color} = {8'h55, 3'd1, 3'd2};
        end
      end
    end
    cmd_valid = 1'b0; we = 1'b0;
    check({tag, " latency"}, seen ? 32'(n) : 32'hffff_ffff, 32'(expect_n));
    check({tag, " busy held"}, 32'(drops), 32'd0);
    @(negedge clk);
    check({tag, " idle after"}, 32'({cmd_done, cmd_ready, busy}), 32'b010);
  endtask

  initial begin
    m_clear_all();

    // Reset values, then the power-up clear.
    #1 rst_n = 1'b0;
    #10;
    check("reset outputs", 32'(cur()), 32'(BLANK));
    check("reset status", 32'({cmd_done, cmd_ready, busy}), 32'b001);
    @(negedge clk);
    rst_n = 1'b1;
    wait_done("powerup clear", ROWS*COLS, 3000, 0, 0, -1);
    scan_all("powerup blank");

    // Host write / read, out-of-range, read-first.
    host_write(3, 5, {8'h41, 3'd2, 3'd1});
    read_one(3, 5, "rd 3,5");
    check("rd 3,5 const", 32'(cur()), 32'({8'h41, 3'd2, 3'd1}));
    read_one(31, 5, "rd oor row");
    read_one(3, 70, "rd oor col");
    host_write(3, 70, {8'h58, 3'd5, 3'd5});
    host_write(31, 0, {8'h59, 3'd5, 3'd5});
    read_one(4, 0, "oor wr col");
    read_one(ROWS-1, 0, "oor wr row");
    @(negedge clk);
    we = 1'b1; wr_addr = 5'd3; wc_addr = 7'd5;
    {w_ascii, w_fg_color, w_bg_color} = {8'h42, 3'd4, 3'd3};
    r_addr = 5'd3; c_addr = 7'd5;
    exp_q.push_back(model[3][5]);
    @(negedge clk);
    we = 1'b0;
    check("read-first", 32'(cur()), 32'(exp_q.pop_front()));
    model[3][5] = {8'h42, 3'd4, 3'd3};
    read_one(3, 5, "after rf write");

    // Fill every row with its digit, then scroll once.
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        @(negedge clk);
        we = 1'b1; wr_addr = 5'(r); wc_addr = 7'(c);
        {w_ascii, w_fg_color, w_bg_color} = {8'(8'h30 + r), 3'(r), 3'(r + 1)};
        model[r][c] = {8'(8'h30 + r), 3'(r), 3'(r + 1)};
      end
    @(negedge clk);
    we = 1'b0;
    issue(2'b01, 0);
    wait_done("scroll1", COLS + 1, 200, 0, 0, -1);
    m_scroll();
    read_ascii(0, 0, 8'h31, "scroll row0");
    read_ascii(28, 69, 8'h4D, "scroll row28");
    read_ascii(29, 10, 8'h20, "scroll row29");
    scan_all("scroll1 screen");

    // 29 more scrolls: base wraps; markers written into the new bottom row.
    for (int k = 2; k <= ROWS; k++) begin
      issue(2'b01, 0);
      wait_done("scrollN", COLS + 1, 200, 0, 0, -1);
      m_scroll();
      host_write(ROWS - 1, k, {8'(8'h60 + k), 3'd6, 3'd1});
    end
    read_ascii(0, 0, 8'h20, "wrap row0 blank");
    scan_all("wrap screen");

    // Clear-all with 10 stalling host writes.
    issue(2'b00, 0);
    wait_done("clear stalled", ROWS*COLS + 1 + 10, 3000, 0, 5, 14);
    m_clear_all();
    scan_all("clear stalled screen");

    // Clear-row at a nonzero base, reserved op, out-of-range row.
    host_write(5, 1, {8'h61, 3'd1, 3'd1});
    issue(2'b01, 0);
    wait_done("scroll base1", COLS + 1, 200, 0, 0, -1);
    m_scroll();
    host_write(7, 3, {8'h62, 3'd2, 3'd3});
    host_write(8, 3, {8'h63, 3'd3, 3'd2});
    issue(2'b10, 7);
    wait_done("clear row7", COLS + 1, 200, 0, 0, -1);
    for (int c = 0; c < COLS; c++) model[7][c] = BLANK;
    read_one(7, 3, "row7 cleared");
    read_one(8, 3, "row8 kept");
    read_one(4, 1, "row4 kept");
    issue(2'b11, 0);
    wait_done("reserved op", 1, 20, 0, 0, -1);
    issue(2'b10, 31);
    wait_done("clear row oor", 1, 20, 0, 0, -1);
    scan_all("after row ops");

    // Async reset in the middle of a row clear.
    @(negedge clk);
    r_addr = 5'd8; c_addr = 7'd3;
    issue(2'b10, 2);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("pre-reset read", 32'(ascii), 32'h63);
    #2 rst_n = 1'b0;
    #1;
    check("async reset outputs", 32'(cur()), 32'(BLANK));
    check("async reset status", 32'({cmd_done, cmd_ready, busy}), 32'b001);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_done("rerun clear", ROWS*COLS, 3000, 100, 0, -1);
    m_clear_all();
    host_write(0, 0, {8'h71, 3'd2, 3'd2});
    host_write(29, 69, {8'h72, 3'd3, 3'd3});
    scan_all("after rerun");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
